// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// led_pattern_sequencer : prescaled 8-LED ring/bounce/blink pattern generator
// Rev 1.0
// ============================================================================
`default_nettype none

module led_pattern_sequencer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       sys_rst_i,
   input  logic       run_i,
   input  logic [1:0] mode_i,
   input  logic       mode_valid_i,
   output logic       mode_ready_o,
   output logic [7:0] led_o,
   output logic       step_o
);

   localparam int unsigned     CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   localparam logic [1:0] MODE_RING   = 2'b00;
   localparam logic [1:0] MODE_BOUNCE = 2'b01;
   localparam logic [1:0] MODE_BLINK  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RING     = 3'd1,
      ST_BOUNCE_L = 3'd2,
      ST_BOUNCE_R = 3'd3,
      ST_BLINK    = 3'd4
   } state_t;

   logic [CNT_W-1:0] presc_cnt;
   logic             tick;
   logic             accept;
   logic             apply;
   logic             pend_valid;
   logic [1:0]       pend_mode;
   state_t           state;
   state_t           state_nxt;
   logic [7:0]       led_nxt;
   logic             step_nxt;

   assign tick         = run_i && (presc_cnt == CNT_MAX);
   assign mode_ready_o = !pend_valid;
   assign accept       = mode_valid_i && mode_ready_o;
   // A request only becomes pending after its accept edge, so a request
   // accepted in a tick cycle naturally waits for the following tick.
   assign apply        = tick && pend_valid;

   always_ff @(posedge clk_i) begin
      if (sys_rst_i) begin
         presc_cnt <= '0;
      end else if (run_i) begin
         if (presc_cnt == CNT_MAX) begin
            presc_cnt <= '0;
         end else begin
            presc_cnt <= presc_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (sys_rst_i) begin
         pend_valid <= 1'b0;
         pend_mode  <= 2'b00;
      end else if (apply) begin
         pend_valid <= 1'b0;
      end else if (accept) begin
         pend_valid <= 1'b1;
         pend_mode  <= mode_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (sys_rst_i) begin
         state  <= ST_IDLE;
         led_o  <= 8'h00;
         step_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         led_o  <= led_nxt;
         step_o <= step_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      led_nxt   = led_o;
      step_nxt  = 1'b0;
      if (apply) begin
         step_nxt = 1'b1;
         case (pend_mode)
            MODE_RING: begin
               state_nxt = ST_RING;
               led_nxt   = 8'h01;
            end
            MODE_BOUNCE: begin
               state_nxt = ST_BOUNCE_L;
               led_nxt   = 8'h01;
            end
            MODE_BLINK: begin
               state_nxt = ST_BLINK;
               led_nxt   = 8'hFF;
            end
            default: begin
               state_nxt = ST_IDLE;
               led_nxt   = 8'h00;
            end
         endcase
      end else if (tick) begin
         case (state)
            ST_RING: begin
               led_nxt  = {led_o[6:0], led_o[7]};
               step_nxt = 1'b1;
            end
            ST_BOUNCE_L: begin
               step_nxt = 1'b1;
               // Turning at the end keeps each end lit for exactly one tick.
               if (led_o == 8'h80) begin
                  led_nxt   = 8'h40;
                  state_nxt = ST_BOUNCE_R;
               end else begin
                  led_nxt = led_o << 1;
               end
            end
            ST_BOUNCE_R: begin
               step_nxt = 1'b1;
               if (led_o == 8'h01) begin
                  led_nxt   = 8'h02;
                  state_nxt = ST_BOUNCE_L;
               end else begin
                  led_nxt = led_o >> 1;
               end
            end
            ST_BLINK: begin
               led_nxt  = ~led_o;
               step_nxt = 1'b1;
            end
            ST_IDLE: begin
               led_nxt = 8'h00;
            end
            default: begin
               state_nxt = ST_IDLE;
               led_nxt   = 8'h00;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
